nic8_sequencer: RTL
===================

Name: nic8_sequencer

Overview:
Control sequencer for the nic8 datapath (PC, IR, A, B, X, Q registers and shared dbus). It alternates FETCH and EXEC cycles and decodes IR into the 14-bit control word that drives register loads and dbus drivers. It also provides a run/halt/single-step debug handshake and tick/instruction counters for the simulation harness. It sits between the IR and the datapath; the status monitor observes its controlBits output.

Parameters:
START_HALTED, 0, 1 = state after reset is HALT; 0 = state after reset is FETCH.
CNT_W, 16, width of the ticks and instret counters.

Ports:
clk  input  1  system clock; all state changes on posedge.
reset  input  1  synchronous, active-high reset.
ir  input  8  current instruction register.
cond  input  1  jump condition flag from the datapath, sampled in EXEC.
run  input  1  level: 1 = free-run, 0 = stop at the next instruction boundary.
step_req  input  1  single-step request; rising edge sampled.
controlBits  output  14  {loadIR,loadPC,loadA,loadB,loadX,doOut,storeMem,assertM,assertE,assertA,assertX,immediate,doSubtract,doJump}; MSB is loadIR.
incPC  output  1  PC increment strobe.
step_ack  output  1  one-cycle pulse when a single-stepped instruction completes.
halted  output  1  1 while in HALT or TRAP.
trapped  output  1  sticky; set by the halt opcode.
ticks  output  CNT_W  posedge count since reset; wraps modulo 2^CNT_W.
instret  output  CNT_W  count of completed EXEC cycles; wraps.

Behaviour:
- States: FETCH, EXEC, HALT, TRAP. Outputs are a combinational decode of state and ir. Counters, step_ack and trapped are registered.
- Reset (synchronous) gives:
  - state = HALT if START_HALTED else FETCH.
  - ticks = instret = 0; step_ack = 0; trapped = 0; step edge detector cleared.
  - During the reset cycle controlBits = 0 and incPC = 0, whatever the state.
  - Reset asserted in any state, including mid-EXEC, aborts the instruction. instret is not incremented.
- FETCH drives loadIR = assertM = immediate = 1 and incPC = 1. All other bits are 0. Next state is EXEC.
- EXEC decode:
  - ir[7:6] src: 0 = M, 1 = E, 2 = A, 3 = X. Exactly one assert bit is set.
  - ir[5:3] dst: 0 = loadA, 1 = loadB, 2 = loadX, 3 = doOut, 4 = storeMem, 5 = loadPC with doJump = 1, 6 = loadPC and doJump both equal cond, 7 = halt opcode (no load bits).
  - ir[2] = 1 (immediate): forces assertM = 1 and other asserts 0; immediate = 1; incPC = 1.
  - doSubtract = ir[1] only when the effective source is E, else 0. ir[0] is ignored.
- EXEC next state, in priority order:
  1. dst = 7: go to TRAP and set trapped.
  2. Stepping (entered from HALT by step): go to HALT and pulse step_ack.
  3. run = 0: go to HALT.
  4. Otherwise: go to FETCH.
  - instret increments on every completed EXEC, including the halt opcode.
- HALT:
  - controlBits = 0, incPC = 0.
  - run = 1: go to FETCH. This takes priority over a simultaneous step edge; no step_ack is given.
  - Rising edge of step_req with run = 0: go to FETCH in stepping mode, executing exactly one instruction.
  - step_req held high executes only one instruction.
- TRAP: controlBits = 0. The only exit is reset. run and step_req are ignored.
- ticks increments every non-reset cycle in every state.
- halted = 1 exactly when state is HALT or TRAP.

Test Plan:
- Reset with START_HALTED = 0, run = 1, ir = 8'h00 -> cycle 1 FETCH: controlBits = 14'b10000001000100, incPC = 1. Cycle 2 EXEC: assertM = loadA = 1. instret = 1 after two posedges.
- ir = 8'h42 in EXEC -> assertE = loadA = doSubtract = 1, incPC = 0. ir = 8'h44 -> assertM = immediate = loadA = 1, incPC = 1, doSubtract = 0.
- ir = 8'h30 -> cond = 0 gives loadPC = doJump = 0 with assertM = 1. cond = 1 gives loadPC = doJump = 1. ir = 8'h28 gives loadPC = doJump = 1 regardless of cond.
- START_HALTED = 1, run = 0, step_req held high for 5 cycles -> exactly one FETCH then one EXEC, step_ack high for one cycle, instret = 1, halted = 1 afterwards. Raising run and step_req together in HALT -> FETCH next cycle, no step_ack.
- ir = 8'h38 while running -> TRAP, trapped = halted = 1, controlBits = 0. Toggling run and step_req has no effect. Reset clears trapped.
- Reset asserted in an EXEC cycle -> instret unchanged, next state FETCH, ticks = 0. CNT_W = 4 with 17 run cycles -> ticks wraps to 1.

Source files
------------

// File: rtl/nic8_sequencer.sv
// ============================================================================
//  Module   : nic8_sequencer
//  Purpose  : Control sequencer for the nic8 datapath. Alternates FETCH and
//             EXEC cycles, decodes IR into the 14-bit control word, and
//             offers a run/halt/single-step debug handshake plus free-running
//             tick and retired-instruction counters.
//  Ports    : clk, reset       - clock, synchronous active-high reset
//             ir, cond         - instruction register, jump condition
//             run, step_req    - free-run level, single-step request
//             controlBits      - {loadIR,loadPC,loadA,loadB,loadX,doOut,
//                                 storeMem,assertM,assertE,assertA,assertX,
//                                 immediate,doSubtract,doJump}
//             incPC            - PC increment strobe
//             step_ack         - pulse when a stepped instruction completes
//             halted, trapped  - debug status
//             ticks, instret   - cycle and retired-instruction counters
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nic8_sequencer #(
    parameter bit START_HALTED = 1'b0,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       ir,
    input  logic             cond,
    input  logic             run,
    input  logic             step_req,
    output logic [13:0]      controlBits,
    output logic             incPC,
    output logic             step_ack,
    output logic             halted,
    output logic             trapped,
    output logic [CNT_W-1:0] ticks,
    output logic [CNT_W-1:0] instret
);

    // Bit positions inside controlBits
    localparam int c_LOAD_IR   = 13;
    localparam int c_LOAD_PC   = 12;
    localparam int c_LOAD_A    = 11;
    localparam int c_LOAD_B    = 10;
    localparam int c_LOAD_X    = 9;
    localparam int c_DO_OUT    = 8;
    localparam int c_STORE_MEM = 7;
    localparam int c_ASSERT_M  = 6;
    localparam int c_ASSERT_E  = 5;
    localparam int c_ASSERT_A  = 4;
    localparam int c_ASSERT_X  = 3;
    localparam int c_IMMEDIATE = 2;
    localparam int c_DO_SUB    = 1;
    localparam int c_DO_JUMP   = 0;

    localparam logic [2:0] c_DST_HALT = 3'd7;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_stepping;
    logic               w_stepping_nxt;
    logic               r_step_q;
    logic               r_step_ack;
    logic               r_trapped;
    logic [CNT_W-1:0]   r_ticks;
    logic [CNT_W-1:0]   r_instret;

    logic [13:0]        w_ctrl;
    logic               w_inc;
    logic [1:0]         w_src;
    logic [2:0]         w_dst;
    logic               w_imm;
    logic               w_step_rise;
    logic               w_in_exec;

    assign w_src       = ir[7:6];
    assign w_dst       = ir[5:3];
    assign w_imm       = ir[2];
    assign w_step_rise = step_req & ~r_step_q;
    assign w_in_exec   = (r_state == S_EXEC);

    // ------------------------------------------------------------------
    // Next-state and control-word decode
    // ------------------------------------------------------------------
    always_comb begin
        w_ctrl         = '0;
        w_inc          = 1'b0;
        w_next         = r_state;
        w_stepping_nxt = r_stepping;

        case (r_state)
            S_FETCH: begin
                w_ctrl[c_LOAD_IR]   = 1'b1;
                w_ctrl[c_ASSERT_M]  = 1'b1;
                w_ctrl[c_IMMEDIATE] = 1'b1;
                w_inc               = 1'b1;
                w_next              = S_EXEC;
            end

            S_EXEC: begin
                // Immediate operands always come from memory at PC
                if (w_imm) begin
                    w_ctrl[c_ASSERT_M]  = 1'b1;
                    w_ctrl[c_IMMEDIATE] = 1'b1;
                    w_inc               = 1'b1;
                end else begin
                    case (w_src)
                        2'd0: w_ctrl[c_ASSERT_M] = 1'b1;
                        2'd1: begin
                            w_ctrl[c_ASSERT_E] = 1'b1;
                            w_ctrl[c_DO_SUB]   = ir[1];
                        end
                        2'd2: w_ctrl[c_ASSERT_A] = 1'b1;
                        default: w_ctrl[c_ASSERT_X] = 1'b1;
                    endcase
                end

                case (w_dst)
                    3'd0: w_ctrl[c_LOAD_A]    = 1'b1;
                    3'd1: w_ctrl[c_LOAD_B]    = 1'b1;
                    3'd2: w_ctrl[c_LOAD_X]    = 1'b1;
                    3'd3: w_ctrl[c_DO_OUT]    = 1'b1;
                    3'd4: w_ctrl[c_STORE_MEM] = 1'b1;
                    3'd5: begin
                        w_ctrl[c_LOAD_PC] = 1'b1;
                        w_ctrl[c_DO_JUMP] = 1'b1;
                    end
                    3'd6: begin
                        w_ctrl[c_LOAD_PC] = cond;
                        w_ctrl[c_DO_JUMP] = cond;
                    end
                    default: ;  // halt opcode: no loads
                endcase

                w_stepping_nxt = 1'b0;
                if (w_dst == c_DST_HALT)
                    w_next = S_TRAP;
                else if (r_stepping)
                    w_next = S_HALT;
                else if (!run)
                    w_next = S_HALT;
                else
                    w_next = S_FETCH;
            end

            S_HALT: begin
                // run wins over a coincident step edge and starts free-running
                if (run) begin
                    w_next         = S_FETCH;
                    w_stepping_nxt = 1'b0;
                end else if (w_step_rise) begin
                    w_next         = S_FETCH;
                    w_stepping_nxt = 1'b1;
                end
            end

            default: ;  // S_TRAP: only reset leaves
        endcase

        // Nothing may be driven onto the datapath while reset is held
        if (reset) begin
            w_ctrl = '0;
            w_inc  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State, handshake and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= START_HALTED ? S_HALT : S_FETCH;
            r_stepping <= 1'b0;
            r_step_q   <= 1'b0;
            r_step_ack <= 1'b0;
            r_trapped  <= 1'b0;
            r_ticks    <= '0;
            r_instret  <= '0;
        end else begin
            r_state    <= w_next;
            r_stepping <= w_stepping_nxt;
            r_step_q   <= step_req;
            r_step_ack <= w_in_exec & r_stepping & (w_dst != c_DST_HALT);
            r_trapped  <= r_trapped | (w_in_exec & (w_dst == c_DST_HALT));
            r_ticks    <= r_ticks + CNT_W'(1);
            if (w_in_exec)
                r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign controlBits = w_ctrl;
    assign incPC       = w_inc;
    assign step_ack    = r_step_ack;
    assign halted      = (r_state == S_HALT) || (r_state == S_TRAP);
    assign trapped     = r_trapped;
    assign ticks       = r_ticks;
    assign instret     = r_instret;

endmodule

`default_nettype wire
